// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer with commit and branch-mispredict flush.
//
// Entries are addressed by tag 1..2^ROB_ID_W-1. Tag 0 means "no rename" and is
// never allocated. Allocation is made at the tail. Writebacks are accepted out of
// order. Commits leave strictly from the head, at most one per cycle.
//
// Committing an entry that carries a mispredict runs a short flush sequence:
// IDLE -> DRAIN -> ROLLBACK -> IDLE.
//   DRAIN    : the branch's own commit pulse is on the outputs.
//   ROLLBACK : rollback_signal/rollback_pc redirect the front end.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   rdy                 global enable; low freezes every register
//   alloc_valid/alloc_rd        allocation request (rd 0 = no destination)
//   alloc_tag, rob_full         tag granted this cycle; allocation blocked
//   wb_valid/wb_tag/wb_value/wb_mispredict/wb_target_pc   result bus
//   qry1_tag/qry2_tag -> qryN_ready/qryN_value            operand lookup
//   rob_has_res, result_from_rob, regidx_from_rob, regalias_from_rob  commit
//   rollback_signal, rollback_pc                          flush redirect
//
// Optional feature (macro ROB_PERF_EN): adds commit_count and flush_count
// performance counters. They freeze while rdy is low.

module rob_commit #(
    parameter int ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,

    input  logic                alloc_valid,
    input  logic [4:0]          alloc_rd,
    output logic [ROB_ID_W-1:0] alloc_tag,
    output logic                rob_full,

    input  logic                wb_valid,
    input  logic [ROB_ID_W-1:0] wb_tag,
    input  logic [31:0]         wb_value,
    input  logic                wb_mispredict,
    input  logic [31:0]         wb_target_pc,

    input  logic [ROB_ID_W-1:0] qry1_tag,
    input  logic [ROB_ID_W-1:0] qry2_tag,
    output logic                qry1_ready,
    output logic [31:0]         qry1_value,
    output logic                qry2_ready,
    output logic [31:0]         qry2_value,

    output logic                rob_has_res,
    output logic [31:0]         result_from_rob,
    output logic [4:0]          regidx_from_rob,
    output logic [ROB_ID_W-1:0] regalias_from_rob,

    output logic                rollback_signal,
    output logic [31:0]         rollback_pc
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]         commit_count,
    output logic [31:0]         flush_count
`endif
);

    localparam int DEPTH = 2 ** ROB_ID_W;
    // The highest tag is all ones, and it also equals the number of entries.
    localparam logic [ROB_ID_W-1:0] LAST_TAG = '1;
    localparam logic [ROB_ID_W-1:0] ONE_TAG  = ROB_ID_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ROLLBACK
    } flush_state_t;

    flush_state_t flush_state;

    logic [DEPTH-1:0]    busy;
    logic [DEPTH-1:0]    ready;
    logic [DEPTH-1:0]    mispredict;
    logic [4:0]          rd_q     [DEPTH];
    logic [31:0]         value_q  [DEPTH];
    logic [31:0]         target_q [DEPTH];

    logic [ROB_ID_W-1:0] head;
    logic [ROB_ID_W-1:0] tail;
    logic [ROB_ID_W-1:0] count;
    logic [31:0]         flush_pc;

    logic idle;
    logic alloc_fire;
    logic wb_fire;
    logic commit_fire;
    logic commit_flush;

    // Tags step k -> k+1 and wrap from the last tag back to 1, never to 0.
    function automatic logic [ROB_ID_W-1:0] next_tag(input logic [ROB_ID_W-1:0] t);
        return (t == LAST_TAG) ? ONE_TAG : t + ONE_TAG;
    endfunction

    assign idle         = (flush_state == IDLE);
    assign rob_full     = (count == LAST_TAG) || !idle;
    assign alloc_tag    = tail;
    assign alloc_fire   = alloc_valid && !rob_full && rdy;
    assign wb_fire      = wb_valid && rdy && idle && (wb_tag != '0) && busy[wb_tag];
    // ready is registered, so an entry can commit no earlier than the cycle after its writeback.
    assign commit_fire  = rdy && idle && busy[head] && ready[head];
    assign commit_flush = commit_fire && mispredict[head];

    // Operand lookup: a stored result wins. Otherwise a matching result on the bus this cycle is forwarded.
    always_comb begin
        qry1_ready = 1'b0;
        qry1_value = '0;
        if (qry1_tag != '0 && busy[qry1_tag] && ready[qry1_tag]) begin
            qry1_ready = 1'b1;
            qry1_value = value_q[qry1_tag];
        end else if (qry1_tag != '0 && wb_valid && wb_tag == qry1_tag && busy[qry1_tag]) begin
            qry1_ready = 1'b1;
            qry1_value = wb_value;
        end
    end

    always_comb begin
        qry2_ready = 1'b0;
        qry2_value = '0;
        if (qry2_tag != '0 && busy[qry2_tag] && ready[qry2_tag]) begin
            qry2_ready = 1'b1;
            qry2_value = value_q[qry2_tag];
        end else if (qry2_tag != '0 && wb_valid && wb_tag == qry2_tag && busy[qry2_tag]) begin
            qry2_ready = 1'b1;
            qry2_value = wb_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_state       <= IDLE;
            busy              <= '0;
            ready             <= '0;
            mispredict        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]     <= '0;
                value_q[i]  <= '0;
                target_q[i] <= '0;
            end
            head              <= ONE_TAG;
            tail              <= ONE_TAG;
            count             <= '0;
            flush_pc          <= '0;
            rob_has_res       <= 1'b0;
            result_from_rob   <= '0;
            regidx_from_rob   <= '0;
            regalias_from_rob <= '0;
            rollback_signal   <= 1'b0;
            rollback_pc       <= '0;
        end else if (rdy) begin
            rob_has_res     <= commit_fire;
            rollback_signal <= (flush_state == DRAIN);
            if (commit_fire) begin
                result_from_rob   <= value_q[head];
                regidx_from_rob   <= rd_q[head];
                regalias_from_rob <= head;
            end

            case (flush_state)
                IDLE: begin
                    if (commit_flush) begin
                        // Everything younger than the branch is discarded. Same-cycle
                        // allocation and writeback are dropped along with it.
                        busy        <= '0;
                        ready       <= '0;
                        head        <= next_tag(head);
                        tail        <= next_tag(head);
                        count       <= '0;
                        flush_pc    <= target_q[head];
                        flush_state <= DRAIN;
                    end else begin
                        if (alloc_fire) begin
                            busy[tail]       <= 1'b1;
                            ready[tail]      <= 1'b0;
                            mispredict[tail] <= 1'b0;
                            rd_q[tail]       <= alloc_rd;
                            tail             <= next_tag(tail);
                        end
                        if (wb_fire) begin
                            ready[wb_tag]      <= 1'b1;
                            value_q[wb_tag]    <= wb_value;
                            mispredict[wb_tag] <= wb_mispredict;
                            target_q[wb_tag]   <= wb_target_pc;
                        end
                        if (commit_fire) begin
                            busy[head]  <= 1'b0;
                            ready[head] <= 1'b0;
                            head        <= next_tag(head);
                        end
                        if (alloc_fire && !commit_fire) begin
                            count <= count + ONE_TAG;
                        end else if (!alloc_fire && commit_fire) begin
                            count <= count - ONE_TAG;
                        end
                    end
                end
                DRAIN: begin
                    rollback_pc <= flush_pc;
                    flush_state <= ROLLBACK;
                end
                default: begin
                    flush_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ROB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_count <= '0;
            flush_count  <= '0;
        end else if (rdy) begin
            if (rob_has_res) begin
                commit_count <= commit_count + 32'd1;
            end
            if (rollback_signal) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [3:0]  alloc_tag;
    logic        rob_full;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value;
    logic        wb_mispredict;
    logic [31:0] wb_target_pc;
    logic [3:0]  qry1_tag;
    logic [3:0]  qry2_tag;
    logic        qry1_ready;
    logic [31:0] qry1_value;
    logic        qry2_ready;
    logic [31:0] qry2_value;
    logic        rob_has_res;
    logic [31:0] result_from_rob;
    logic [4:0]  regidx_from_rob;
    logic [3:0]  regalias_from_rob;
    logic        rollback_signal;
    logic [31:0] rollback_pc;

    rob_commit #(.ROB_ID_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .alloc_valid       (alloc_valid),
        .alloc_rd          (alloc_rd),
        .alloc_tag         (alloc_tag),
        .rob_full          (rob_full),
        .wb_valid          (wb_valid),
        .wb_tag            (wb_tag),
        .wb_value          (wb_value),
        .wb_mispredict     (wb_mispredict),
        .wb_target_pc      (wb_target_pc),
        .qry1_tag          (qry1_tag),
        .qry2_tag          (qry2_tag),
        .qry1_ready        (qry1_ready),
        .qry1_value        (qry1_value),
        .qry2_ready        (qry2_ready),
        .qry2_value        (qry2_value),
        .rob_has_res       (rob_has_res),
        .result_from_rob   (result_from_rob),
        .regidx_from_rob   (regidx_from_rob),
        .regalias_from_rob (regalias_from_rob),
        .rollback_signal   (rollback_signal),
        .rollback_pc       (rollback_pc)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [31:0] value;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] rds [16];
    logic [3:0] exp_tail;
    logic [3:0] tt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] nxt(input logic [3:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] t, input logic [4:0] r, input logic [31:0] v);
        exp_t e;
        e.tag   = t;
        e.rd    = r;
        e.value = v;
        sb.push_back(e);
    endtask

    // Called only after an enabled edge, so a frozen output is never counted twice.
    task automatic monitor();
        exp_t e;
        if (rob_has_res === 1'b1) begin
            check("commit_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("commit_tag", 32'(regalias_from_rob), 32'(e.tag));
                check("commit_rd", 32'(regidx_from_rob), 32'(e.rd));
                check("commit_value", result_from_rob, e.value);
            end
        end
    endtask

    task automatic tick();
        logic en;
        en = rdy && rst;
        @(posedge clk);
        #1;
        if (en) monitor();
    endtask

    task automatic do_alloc(input logic [4:0] r);
        alloc_valid = 1'b1;
        alloc_rd    = r;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] t, input logic [31:0] v, input logic m, input logic [31:0] pc);
        wb_valid      = 1'b1;
        wb_tag        = t;
        wb_value      = v;
        wb_mispredict = m;
        wb_target_pc  = pc;
        tick();
        wb_valid      = 1'b0;
        wb_mispredict = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        alloc_valid = 1'b0; alloc_rd = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_value = '0; wb_mispredict = 1'b0; wb_target_pc = '0;
        qry1_tag = '0; qry2_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alloc_tag", 32'(alloc_tag), 32'd1);
        check("rst_full", 32'(rob_full), 32'd0);
        check("rst_has_res", 32'(rob_has_res), 32'd0);
        check("rst_rollback", 32'(rollback_signal), 32'd0);
        rst = 1'b1;

        // Basic allocate / writeback / commit latency
        check("alloc_tag_first", 32'(alloc_tag), 32'd1);
        do_alloc(5'd5);
        push_exp(4'd1, 5'd5, 32'h1234);
        do_wb(4'd1, 32'h1234, 1'b0, 32'h0);
        check("lat_no_commit_yet", 32'(rob_has_res), 32'd0);
        tick();
        check("lat_commit", 32'(rob_has_res), 32'd1);
        tick();
        check("commit_single_pulse", 32'(rob_has_res), 32'd0);

        // Fill to 15 entries, refuse the 16th, free one by commit, wrap the tail
        exp_tail = 4'd2;
        for (int i = 0; i < 15; i++) begin
            check("alloc_tag_seq", 32'(alloc_tag), 32'(exp_tail));
            rds[exp_tail] = 5'(i + 1);
            do_alloc(5'(i + 1));
            exp_tail = nxt(exp_tail);
        end
        check("full_at_15", 32'(rob_full), 32'd1);
        check("tail_wrapped", 32'(alloc_tag), 32'd2);
        do_alloc(5'd31);
        check("refused_16th_tag", 32'(alloc_tag), 32'd2);
        check("refused_16th_full", 32'(rob_full), 32'd1);
        push_exp(4'd2, rds[2], 32'h200);
        do_wb(4'd2, 32'h200, 1'b0, 32'h0);
        check("full_until_commit", 32'(rob_full), 32'd1);
        tick();
        check("not_full_after_commit", 32'(rob_full), 32'd0);
        tt = 4'd3;
        for (int k = 0; k < 14; k++) begin
            push_exp(tt, rds[tt], 32'h1000 + 32'(tt));
            do_wb(tt, 32'h1000 + 32'(tt), 1'b0, 32'h0);
            tt = nxt(tt);
        end
        drain();

        // Out-of-order writebacks commit in order; the middle entry has rd 0
        do_alloc(5'd7);
        do_alloc(5'd0);
        do_alloc(5'd9);
        push_exp(4'd2, 5'd7, 32'h22);
        push_exp(4'd3, 5'd0, 32'h33);
        push_exp(4'd4, 5'd9, 32'h44);
        do_wb(4'd4, 32'h44, 1'b0, 32'h0);
        do_wb(4'd3, 32'h33, 1'b0, 32'h0);
        do_wb(4'd2, 32'h22, 1'b0, 32'h0);
        check("ooo_wait", 32'(rob_has_res), 32'd0);
        tick();
        check("ooo_c1", 32'(rob_has_res), 32'd1);
        tick();
        check("ooo_c2", 32'(rob_has_res), 32'd1);
        check("rd_zero_commit", 32'(regidx_from_rob), 32'd0);
        tick();
        check("ooo_c3", 32'(rob_has_res), 32'd1);
        tick();
        check("ooo_done", 32'(rob_has_res), 32'd0);

        // Same-cycle bypass on the query port
        do_alloc(5'd3);
        qry1_tag = 4'd5;
        qry2_tag = 4'd6;
        #1;
        check("qry_not_ready", 32'(qry1_ready), 32'd0);
        wb_valid = 1'b1; wb_tag = 4'd5; wb_value = 32'd7;
        #1;
        check("qry_bypass_ready", 32'(qry1_ready), 32'd1);
        check("qry_bypass_value", qry1_value, 32'd7);
        check("qry2_idle_ready", 32'(qry2_ready), 32'd0);
        check("qry2_idle_value", qry2_value, 32'd0);
        push_exp(4'd5, 5'd3, 32'd7);
        tick();
        wb_valid = 1'b0;
        #1;
        check("qry_stored_value", qry1_value, 32'd7);
        drain();

        // Mispredict flush: tags 8 and 9 are ready but must never commit
        do_alloc(5'd1);
        do_alloc(5'd2);
        do_alloc(5'd3);
        do_alloc(5'd4);
        do_wb(4'd8, 32'h88, 1'b0, 32'h0);
        do_wb(4'd9, 32'h99, 1'b0, 32'h0);
        do_wb(4'd7, 32'h77, 1'b1, 32'h100);
        push_exp(4'd6, 5'd1, 32'h66);
        push_exp(4'd7, 5'd2, 32'h77);
        do_wb(4'd6, 32'h66, 1'b0, 32'h0);
        check("flush_pre", 32'(rob_has_res), 32'd0);
        tick();
        check("flush_c6", 32'(regalias_from_rob), 32'd6);
        tick();
        check("flush_branch_commit", 32'(regalias_from_rob), 32'd7);
        check("drain_no_rollback", 32'(rollback_signal), 32'd0);
        check("full_in_drain", 32'(rob_full), 32'd1);
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        tick();
        alloc_valid = 1'b0;
        check("rollback_signal", 32'(rollback_signal), 32'd1);
        check("rollback_pc", rollback_pc, 32'h100);
        check("rollback_no_commit", 32'(rob_has_res), 32'd0);
        tick();
        check("rollback_pulse_end", 32'(rollback_signal), 32'd0);
        check("full_after_flush", 32'(rob_full), 32'd0);
        check("tail_after_flush", 32'(alloc_tag), 32'd8);
        qry1_tag = 4'd9;
        #1;
        check("flushed_entry_gone", 32'(qry1_ready), 32'd0);
        repeat (5) tick();

        // rdy low for three cycles in the middle of a commit stream
        do_alloc(5'd10);
        do_alloc(5'd11);
        do_alloc(5'd12);
        push_exp(4'd8, 5'd10, 32'hA8);
        push_exp(4'd9, 5'd11, 32'hA9);
        push_exp(4'd10, 5'd12, 32'hAA);
        do_wb(4'd8, 32'hA8, 1'b0, 32'h0);
        do_wb(4'd9, 32'hA9, 1'b0, 32'h0);
        do_wb(4'd10, 32'hAA, 1'b0, 32'h0);
        check("stall_pre_commit", 32'(regalias_from_rob), 32'd9);
        rdy = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd1;
        repeat (3) tick();
        alloc_valid = 1'b0;
        check("stall_frozen_tag", 32'(regalias_from_rob), 32'd9);
        check("stall_no_alloc", 32'(alloc_tag), 32'd11);
        rdy = 1'b1;
        drain();
        repeat (3) tick();

        // Reset during DRAIN aborts the flush
        do_alloc(5'd1);
        push_exp(4'd11, 5'd1, 32'h5);
        do_wb(4'd11, 32'h5, 1'b1, 32'h200);
        tick();
        check("pre_reset_commit", 32'(rob_has_res), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_tag", 32'(alloc_tag), 32'd1);
        check("async_rst_has_res", 32'(rob_has_res), 32'd0);
        check("async_rst_full", 32'(rob_full), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_rollback_after_reset", 32'(rollback_signal), 32'd0);
        end
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
